ha_resp_checker: RTL and testbench
==================================

// Module: ha_resp_checker
// PURPOSE
//  Synthesizable response checker for the half adder / half subtractor cells.
//  Sits on the output side of the cell under test, opposite the stimulus driver.
//  Samples each (a, b, result, carry/borrow) tuple, compares it with the golden
//  truth table, counts vectors and errors, captures the first failure, and
//  flags done/pass once a programmed number of vectors has been checked.
// PARAMETERS
//  N_VECTORS  4  vectors per run; 1 <= N_VECTORS <= 2**CNT_W-1
//  CNT_W      8  width of vec_count, err_count and first_fail_idx
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      asynchronous, active-high reset
//  start           in   1      begin a run; sampled in IDLE and DONE only
//  mode            in   1      0 = half adder check, 1 = half subtractor check
//  in_valid        in   1      tuple on a/b/r/co is valid this cycle
//  in_ready        out  1      checker accepts tuples (high only in RUN)
//  a, b            in   1      operands applied to the cell under test
//  r               in   1      cell result (sum or difference)
//  co              in   1      cell carry or borrow
//  mismatch        out  1      one-cycle pulse: last accepted tuple was wrong
//  vec_count       out  CNT_W  tuples accepted this run
//  err_count       out  CNT_W  mismatches this run
//  first_fail_idx  out  CNT_W  vec_count index (1-based) of first mismatch, 0 if none
//  first_fail_vec  out  4      {a,b,r,co} of first mismatch, 0 if none
//  done            out  1      run complete (level, high in DONE)
//  pass            out  1      done && err_count==0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, in_ready=0. Async assert, sync deassert.
//  Golden model: mode 0: r=a^b, co=a&b. mode 1: r=a^b, co=~a&b.
//  mode is sampled per accepted tuple; changing it mid-run is legal.
//  FSM IDLE -> RUN on start; DONE -> RUN on start; RUN ignores start.
//   Entering RUN clears vec_count, err_count, first_fail_*, done, pass,
//   mismatch on the same edge.
//  Accept = in_valid && in_ready. in_valid outside RUN is ignored, no counting.
//  On an accepting edge: vec_count+=1; on mismatch err_count+=1 and mismatch=1
//   for the next cycle only; first mismatch of a run also loads
//   first_fail_idx=new vec_count and first_fail_vec={a,b,r,co}.
//  Latency: mismatch/counters visible 1 cycle after the accepting edge.
//  When the accept makes vec_count==N_VECTORS: RUN->DONE on that same edge;
//   done=1 and pass=(final err_count==0) from the next cycle; in_ready drops.
//  No wrap: N_VECTORS limit bounds both counters; no counter overflows.
//  DONE holds every result until start (re-run) or rst.
//  start together with in_valid in IDLE/DONE: start wins, tuple ignored.
//  rst mid-run: returns to IDLE immediately, all results lost.
// TESTING
//  1 mode0, start, 4 correct tuples 00/00,01/10,10/10,11/01 back-to-back
//    -> done=1, pass=1, vec_count=4, err_count=0, first_fail_idx=0.
//  2 mode0, tuple 3 driven as a=1,b=1,r=0,co=0 -> mismatch pulse 1 cycle,
//    err_count=1, first_fail_idx=4, first_fail_vec=4'b1100, pass=0.
//  3 mode1, a=0,b=1,r=1,co=1 and a=1,b=0,r=1,co=0 plus 2 more correct
//    -> pass=1; same tuples checked under mode0 -> err_count=1 (idx 1).
//  4 in_valid toggled in IDLE and DONE -> vec_count unchanged; start during
//    RUN -> no clear, run continues.
//  5 rst asserted after 2 accepts, mid-cycle -> outputs 0 without clock edge;
//    new start then 4 tuples -> vec_count=4, done=1.
//  6 in_valid gaps (1 of 3 cycles) -> counts only accepted cycles; DONE then
//    start -> counters cleared, second run passes independently.

Source files
------------

// File: rtl/ha_resp_checker_if.sv
// Tuple stream from the cell under test into the response checker, plus the
// checker's run results. master = stimulus side, slave = checker.
interface ha_resp_checker_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic             a;
  logic             b;
  logic             r;
  logic             co;
  logic             mismatch;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_fail_idx;
  logic [3:0]       first_fail_vec;
  logic             done;
  logic             pass;

  modport master (
    output start, mode, in_valid, a, b, r, co,
    input  in_ready, mismatch, vec_count, err_count,
           first_fail_idx, first_fail_vec, done, pass
  );

  modport slave (
    input  start, mode, in_valid, a, b, r, co,
    output in_ready, mismatch, vec_count, err_count,
           first_fail_idx, first_fail_vec, done, pass
  );
endinterface

// File: rtl/ha_resp_checker.sv
// Response checker for half adder / half subtractor cells: compares each accepted
// {a,b,r,co} tuple with the truth table, counts errors, captures the first failure.
module ha_resp_checker #(
  parameter int N_VECTORS = 4,
  parameter int CNT_W     = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  ha_resp_checker_if.slave bus
);

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // RUN    | accepting and checking tuples
  // DONE   | N_VECTORS checked, results held until start
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [3:0]       ffv_q, ffv_d;
  logic             mis_q, mis_d;

  logic accept;
  logic exp_r;
  logic exp_co;
  logic bad;

  assign accept = bus.in_valid && (state_q == S_RUN);
  assign exp_r  = bus.a ^ bus.b;
  assign exp_co = bus.mode ? (~bus.a & bus.b) : (bus.a & bus.b);
  assign bad    = (bus.r != exp_r) || (bus.co != exp_co);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    mis_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = '0;
          err_d   = '0;
          ffi_d   = '0;
          ffv_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          vec_d = vec_q + CNT_W'(1);
          if (bad) begin
            err_d = err_q + CNT_W'(1);
            mis_d = 1'b1;
            if (err_q == '0) begin
              ffi_d = vec_d;
              ffv_d = {bus.a, bus.b, bus.r, bus.co};
            end
          end
          // Terminal count bounds both counters, so neither can wrap.
          if (vec_d == CNT_W'(N_VECTORS)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.in_ready       = (state_q == S_RUN);
  assign bus.mismatch       = mis_q;
  assign bus.vec_count      = vec_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_vec = ffv_q;
  assign bus.done           = (state_q == S_DONE);
  assign bus.pass           = (state_q == S_DONE) && (err_q == '0);

endmodule

// File: tb/tb_ha_resp_checker.sv
// Bench for ha_resp_checker: directed scenarios plus random tuple streams, all
// outputs compared each cycle against a truth-table based reference model.
module tb_ha_resp_checker;
  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ha_resp_checker_if #(.CNT_W(CNT_W)) bus ();

  ha_resp_checker #(.N_VECTORS(N), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  bit m_run, m_done, m_mis;
  int m_vec, m_err, m_ffi, m_ffv;

  function automatic logic [1:0] golden(input logic m, input logic a, input logic b);
    int  s;
    logic rr, cc;
    s  = m ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    rr = (s % 2) != 0;
    cc = m ? (s < 0) : (s > 1);
    return {rr, cc};
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_mis = 0;
    m_vec = 0; m_err = 0; m_ffi = 0; m_ffv = 0;
  endtask

  task automatic model_edge(input bit st, input bit md, input bit vl,
                            input bit a, input bit b, input bit r, input bit co);
    logic [1:0] g;
    m_mis = 0;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_done = 0;
        m_vec = 0; m_err = 0; m_ffi = 0; m_ffv = 0;
      end
    end else if (vl) begin
      m_vec++;
      g = golden(md, a, b);
      if (g != {r, co}) begin
        m_err++;
        m_mis = 1;
        if (m_err == 1) begin
          m_ffi = m_vec;
          m_ffv = {28'd0, a, b, r, co};
        end
      end
      if (m_vec == N) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, int'(bus.in_ready), int'(m_run));
    chk({tag, ".mismatch"}, int'(bus.mismatch), int'(m_mis));
    chk({tag, ".vec_count"}, int'(bus.vec_count), m_vec);
    chk({tag, ".err_count"}, int'(bus.err_count), m_err);
    chk({tag, ".ff_idx"}, int'(bus.first_fail_idx), m_ffi);
    chk({tag, ".ff_vec"}, int'(bus.first_fail_vec), m_ffv);
    chk({tag, ".done"}, int'(bus.done), int'(m_done));
    chk({tag, ".pass"}, int'(bus.pass), int'(m_done && m_err == 0));
  endtask

  task automatic apply(input string tag, input bit st, input bit md, input bit vl,
                       input bit a, input bit b, input bit r, input bit co);
    bus.start = st; bus.mode = md; bus.in_valid = vl;
    bus.a = a; bus.b = b; bus.r = r; bus.co = co;
    @(posedge clk);
    model_edge(st, md, vl, a, b, r, co);
    #1;
    check_all(tag);
  endtask

  task automatic good(input string tag, input bit md, input bit a, input bit b);
    logic [1:0] g;
    g = golden(md, a, b);
    apply(tag, 1'b0, md, 1'b1, a, b, g[1], g[0]);
  endtask

  task automatic idle(input string tag);
    apply(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_run(input string tag);
    apply(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit st, md, vl, a, b;
    logic [1:0] g, f;
    bus.start = 0; bus.mode = 0; bus.in_valid = 0;
    bus.a = 0; bus.b = 0; bus.r = 0; bus.co = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 0;
    idle("idle");

    // 1: clean adder run
    start_run("t1.start");
    good("t1.v0", 0, 0, 0);
    good("t1.v1", 0, 0, 1);
    good("t1.v2", 0, 1, 0);
    good("t1.v3", 0, 1, 1);
    idle("t1.hold");

    // 2: last tuple wrong, mismatch seen for one cycle only
    start_run("t2.start");
    good("t2.v0", 0, 0, 0);
    good("t2.v1", 0, 0, 1);
    good("t2.v2", 0, 1, 0);
    apply("t2.bad", 0, 0, 1, 1, 1, 0, 0);
    idle("t2.after");

    // 3: subtractor tuples, then the same tuples under adder rules
    start_run("t3.start");
    apply("t3.s0", 0, 1, 1, 0, 1, 1, 1);
    apply("t3.s1", 0, 1, 1, 1, 0, 1, 0);
    good("t3.s2", 1, 0, 0);
    good("t3.s3", 1, 1, 1);
    start_run("t3.restart");
    apply("t3.a0", 0, 0, 1, 0, 1, 1, 1);
    apply("t3.a1", 0, 0, 1, 1, 0, 1, 0);
    good("t3.a2", 0, 0, 0);
    good("t3.a3", 0, 1, 1);

    // 4: in_valid in DONE ignored; start during RUN ignored; start beats in_valid
    apply("t4.done_vld", 0, 0, 1, 1, 1, 0, 0);
    apply("t4.done_vld2", 0, 0, 1, 0, 0, 1, 1);
    apply("t4.start_vld", 1, 0, 1, 1, 1, 0, 0);
    good("t4.v0", 0, 1, 1);
    apply("t4.run_start", 1, 0, 1, 0, 1, 1, 0);
    good("t4.v2", 0, 0, 0);
    good("t4.v3", 0, 1, 0);

    // 5: reset mid-run, observed without a clock edge
    start_run("t5.start");
    good("t5.v0", 0, 0, 1);
    apply("t5.v1", 0, 0, 1, 0, 0, 1, 0);
    #3;
    rst = 1;
    model_reset();
    #1;
    check_all("t5.async_rst");
    @(negedge clk);
    rst = 0;
    apply("t5.idle_vld", 0, 0, 1, 1, 1, 0, 1);
    start_run("t5.restart");
    good("t5.r0", 1, 0, 1);
    good("t5.r1", 0, 1, 1);
    good("t5.r2", 1, 1, 0);
    good("t5.r3", 0, 0, 0);

    // 6: valid gaps, then an independent second run
    start_run("t6.start");
    for (int i = 0; i < N; i++) begin
      idle("t6.gap");
      idle("t6.gap");
      good("t6.v", i[0], i[1], i[0]);
    end
    start_run("t6.rerun");
    for (int i = 0; i < N; i++) good("t6.w", 1, i[0], i[1]);

    // random streams with injected errors and stray starts
    for (int k = 0; k < 300; k++) begin
      st = ($urandom % 8) == 0;
      vl = ($urandom % 3) != 0;
      md = $urandom % 2;
      a  = $urandom % 2;
      b  = $urandom % 2;
      g  = golden(md, a, b);
      f  = (($urandom % 4) == 0) ? 2'(1 + $urandom % 3) : 2'b00;
      g  = g ^ f;
      apply("rand", st, md, vl, a, b, g[1], g[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
